neural_mac_pe: RTL and testbench

Parametrised multiply-accumulate processing element for fully connected layers; next generation of the single-lane neuron cell. Consumes LANES input/weight pairs per beat over a vector of arbitrary length. Adds a bias, rescales signed fixed-point, saturates, optionally applies ReLU, and presents one result under a valid/ready handshake. Sits between the activation/weight fetch logic and the layer output buffer.

---
 rtl/neural_pkg.sv | 42 ++++
 rtl/neural_lane_mult.sv | 38 +++
 rtl/neural_mac_pe.sv | 140 ++++++++++++++
 tb/tb_neural_mac_pe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neural_pkg.sv
// Shared types and helpers for the neural MAC processing element.
// Holds the controller state type, accumulator sizing and output saturation.
package neural_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        FINAL,
        OUT
    } state_t;

    // Widest accumulator the saturation helpers accept
    localparam int SAT_W = 64;

    function automatic int acc_width(input int w, input int lanes, input int guard);
        return 2 * w + $clog2(lanes) + guard;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_clip(input logic signed [SAT_W-1:0] v,
                                                        input int unsigned w);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = 1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic sat_hit(input logic signed [SAT_W-1:0] v, input int unsigned w);
        logic signed [SAT_W-1:0] one;
        one = 1;
        return (v > ((one <<< (w - 1)) - one)) || (v < -(one <<< (w - 1)));
    endfunction

endpackage

// File: rtl/neural_lane_mult.sv
// Registered signed W x W multiplier lane with a valid bit.
// i_flush discards the product currently held in the stage.
module neural_lane_mult
    import neural_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [W-1:0]          i_a,
    input  logic [W-1:0]          i_b,
    output logic                  o_valid,
    output logic signed [2*W-1:0] o_prod
);

    logic                  r_valid;
    logic signed [2*W-1:0] r_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_prod  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_prod <= (2*W)'($signed(i_a)) * (2*W)'($signed(i_b));
            end
        end
    end

    assign o_valid = r_valid;
    assign o_prod  = r_prod;

endmodule

// File: rtl/neural_mac_pe.sv
// Multi-lane multiply-accumulate PE: dot product + bias, fixed-point rescale,
// saturation and optional ReLU, with one result presented under valid/ready.
module neural_mac_pe
    import neural_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 2,
    parameter int GUARD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [LANES*W-1:0] in_data,
    input  logic [LANES*W-1:0] weight_data,
    input  logic [W-1:0]       bias_data,
    input  logic               relu_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               out_sat,
    output logic               busy
);

    localparam int ACC_W = acc_width(W, LANES, GUARD);

    state_t                  r_state;
    state_t                  w_next;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [W-1:0]     r_bias;
    logic                    r_relu;
    logic [W-1:0]            r_out_data;
    logic                    r_out_sat;

    logic                    w_accept;
    logic                    w_lane_in;
    logic [LANES-1:0]        w_pv;
    logic signed [2*W-1:0]   w_prod [LANES];
    logic                    w_prod_valid;
    logic signed [ACC_W-1:0] w_lane_sum;
    logic signed [ACC_W-1:0] w_biased;
    logic signed [ACC_W-1:0] w_shifted;
    logic signed [W-1:0]     w_sat;
    logic                    w_clip;
    logic [W-1:0]            w_result;

    assign w_accept     = in_valid & in_ready;
    assign w_lane_in    = w_accept & ~clear;
    assign w_prod_valid = |w_pv;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        neural_lane_mult #(.W(W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_flush(clear),
            .i_valid(w_lane_in),
            .i_a    (in_data[g*W +: W]),
            .i_b    (weight_data[g*W +: W]),
            .o_valid(w_pv[g]),
            .o_prod (w_prod[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        busy     = (r_state != IDLE);
        unique case (r_state)
            IDLE:  if (start) w_next = ACC;
            ACC: begin
                in_ready = 1'b1;
                if (w_accept && in_last) w_next = DRAIN;
            end
            DRAIN: if (w_prod_valid) w_next = FINAL;
            FINAL: w_next = OUT;
            OUT:   if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (clear) w_next = IDLE;
    end

    always_comb begin
        w_lane_sum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lane_sum = w_lane_sum + ACC_W'(w_prod[i]);
        end
    end

    // Bias is aligned to the product scale (2*FRAC) before the shared rescale
    always_comb begin
        w_biased  = r_acc + (ACC_W'(r_bias) <<< FRAC);
        w_shifted = w_biased >>> FRAC;
        w_sat     = W'(sat_clip(SAT_W'(w_shifted), W));
        w_clip    = sat_hit(SAT_W'(w_shifted), W);
        w_result  = (r_relu && w_sat[W-1]) ? '0 : w_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_bias     <= '0;
            r_relu     <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_acc <= '0;
            end else if (w_prod_valid) begin
                r_acc <= r_acc + w_lane_sum;
            end
            if (w_accept && in_last) begin
                r_bias <= bias_data;
                r_relu <= relu_en;
            end
            if (r_state == FINAL) begin
                r_out_data <= w_result;
                r_out_sat  <= w_clip;
            end
        end
    end

    assign out_valid = (r_state == OUT);
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_neural_mac_pe.sv
// Self-checking bench for neural_mac_pe: directed literal cases plus random
// vectors checked every cycle against a dot-product reference model.
module tb_neural_mac_pe;

    logic        clk = 1'b0;
    logic        rst, start, clear, in_valid, in_last, relu_en, out_ready;
    logic [31:0] in_data, weight_data;
    logic [15:0] bias_data;
    logic        in_ready, out_valid, out_sat, busy;
    logic [15:0] out_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        longint data;
        bit     sat;
        int     cyc;
    } exp_t;

    exp_t   q[$];
    longint m_sum = 0;
    bit     seen  = 0;

    neural_mac_pe #(.W(16), .FRAC(8), .LANES(2), .GUARD(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .weight_data(weight_data),
        .bias_data  (bias_data),
        .relu_en    (relu_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: floor((sum + bias*2^8) / 2^8), clip to int16, then optional ReLU
    task automatic model(input longint sum, input logic [15:0] bias, input logic relu,
                         output longint d, output bit s);
        longint v;
        v = (sum + longint'($signed(bias)) * 256) >>> 8;
        s = 0;
        if (v > 32767) begin
            v = 32767;
            s = 1;
        end else if (v < -32768) begin
            v = -32768;
            s = 1;
        end
        if (relu && v < 0) v = 0;
        d = v;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 1, 0);
                end else begin
                    check("model_data", longint'($signed(out_data)), q[0].data);
                    check("model_sat", longint'(out_sat), longint'(q[0].sat));
                    if (!seen) check("latency", cyc, q[0].cyc);
                    seen = 1;
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end else if (q.size() != 0 && cyc >= q[0].cyc) begin
                check("latency_timeout", 0, 1);
                void'(q.pop_front());
                seen = 0;
            end
        end
        if (rst || clear) begin
            q.delete();
            seen  = 0;
            m_sum = 0;
        end else if (in_valid && in_ready) begin
            m_sum += longint'($signed(in_data[15:0])) * longint'($signed(weight_data[15:0]));
            m_sum += longint'($signed(in_data[31:16])) * longint'($signed(weight_data[31:16]));
            if (in_last) begin
                model(m_sum, bias_data, relu_en, e.data, e.sat);
                e.cyc = cyc + 3;
                q.push_back(e);
                m_sum = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [31:0] w, input logic last,
                             input logic [15:0] bias, input logic relu);
        bit done = 0;
        in_valid    = 1'b1;
        in_data     = d;
        weight_data = w;
        in_last     = last;
        bias_data   = bias;
        relu_en     = relu;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                tick();
                done = 1;
                break;
            end
            tick();
        end
        if (!done) check("beat_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input int hold, output logic [15:0] d, output logic s);
        int k = 0;
        while (!out_valid && k < 12) begin
            tick();
            k++;
        end
        d = '0;
        s = 1'b0;
        if (!out_valid) begin
            check("result_timeout", 0, 1);
        end else begin
            repeat (hold) tick();
            d = out_data;
            s = out_sat;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic one_beat(input string nm, input logic [31:0] d, input logic [31:0] w,
                            input logic [15:0] bias, input logic relu,
                            input longint exp_d, input longint exp_s);
        logic [15:0] rd;
        logic        rs;
        do_start();
        send_beat(d, w, 1'b1, bias, relu);
        get_result(0, rd, rs);
        check({nm, "_data"}, longint'($signed(rd)), exp_d);
        check({nm, "_sat"}, longint'(rs), exp_s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic        rs;
        rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        relu_en = 1'b0; out_ready = 1'b0; in_data = '0; weight_data = '0; bias_data = '0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        one_beat("single", {16'd512, 16'd256}, {16'd256, 16'd256}, 16'd256, 1'b0, 1024, 0);
        one_beat("sat_pos", {16'd32767, 16'd32767}, {16'd32767, 16'd32767}, 16'd0, 1'b0, 32767, 1);
        one_beat("sat_neg", {16'h8000, 16'h8000}, {16'd32767, 16'd32767}, 16'd0, 1'b0, -32768, 1);
        one_beat("neg", {16'd0, 16'hFF00}, {16'd0, 16'd256}, 16'd0, 1'b0, -256, 0);
        one_beat("relu", {16'd0, 16'hFF00}, {16'd0, 16'd256}, 16'd0, 1'b1, 0, 0);
        one_beat("floor", {16'd0, 16'hFFFF}, {16'd0, 16'd1}, 16'd0, 1'b0, -1, 0);

        // Four beats with in_valid gaps
        do_start();
        for (int i = 0; i < 4; i++) begin
            send_beat({16'd256, 16'd256}, {16'd256, 16'd256}, i == 3, 16'd0, 1'b0);
            if (i < 3) begin
                tick();
                tick();
                check("gap_in_ready", in_ready, 1);
            end
        end
        check("drain_in_ready", in_ready, 0);
        get_result(0, rd, rs);
        check("four_beat_data", longint'($signed(rd)), 2048);

        // Backpressure with an ignored start pulse
        do_start();
        send_beat({16'd0, 16'd512}, {16'd0, 16'd256}, 1'b1, 16'd0, 1'b0);
        repeat (3) tick();
        for (int j = 0; j < 5; j++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 512);
            check("bp_busy", busy, 1);
            check("bp_in_ready", in_ready, 0);
            start = (j == 2);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_busy", busy, 0);
        check("bp_idle_valid", out_valid, 0);
        tick();
        check("bp_start_ignored", busy, 0);

        // Clear in ACC with a product in flight
        do_start();
        send_beat({16'd1000, 16'd1000}, {16'd1000, 16'd1000}, 1'b0, 16'd0, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_in_ready", in_ready, 0);
        repeat (4) tick();
        one_beat("after_clear", {16'd256, 16'd256}, {16'd256, 16'd256}, 16'd0, 1'b0, 512, 0);

        // Asynchronous reset while draining
        do_start();
        send_beat({16'd300, 16'd300}, {16'd300, 16'd300}, 1'b1, 16'd5, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", out_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        one_beat("after_rst", {16'd512, 16'd256}, {16'd256, 16'd256}, 16'd256, 1'b0, 1024, 0);

        // Random vectors; results checked by the model process
        for (int v = 0; v < 40; v++) begin
            int          n;
            logic [15:0] b;
            logic        r;
            n = $urandom_range(1, 6);
            b = 16'($urandom);
            r = 1'($urandom_range(0, 1));
            do_start();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                send_beat($urandom, $urandom, i == n - 1, b, r);
            end
            get_result($urandom_range(0, 3), rd, rs);
        end

        repeat (5) tick();
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
